ctrl_pipe_hazard: RTL
=====================

// Module: ctrl_pipe_hazard
// PURPOSE
//  Consumer end of the control-bundle interface. Takes the WB/M/EX control bundles produced in ID
//  and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
//  Also carries the register specifiers, detects load-use hazards and resolves branches in MEM.
//  Drives stall/flush and the forwarding selects for the 5-stage MIPS pipeline.
// PARAMETERS
//  RA_W   5  register-specifier width
// PORTS
//  clk             in   1     pipeline clock, all state on rising edge
//  reset           in   1     asynchronous, active-low; clears every pipeline register
//  id_wb           in   2     {memtoreg, regwrite} from control
//  id_m            in   3     {memwrite, memread, branch} from control
//  id_exe          in   4     {alusrc, aluop[1:0], regdst} from control
//  id_rs,id_rt,id_rd in RA_W  specifiers of instruction in ID
//  ex_zero         in   1     ALU zero flag of instruction in EX
//  ex_regdst,ex_alusrc out 1; ex_aluop out 2   EX-stage controls (ID/EX register)
//  ex_rs,ex_rt     out  RA_W  ID/EX specifiers
//  mem_branch,mem_read,mem_write out 1         MEM-stage controls (EX/MEM register)
//  wb_regwrite,wb_memtoreg out 1               WB-stage controls (MEM/WB register)
//  wb_dst          out  RA_W  write-back destination
//  pc_src          out  1     mem_branch & mem_zero; select branch target
//  pc_write,ifid_write out 1  0 = hold PC / IF-ID (load-use stall)
//  ifid_flush      out  1     1 = IF/ID loads a NOP
//  fwd_a,fwd_b     out  2     00 regfile, 10 from EX/MEM, 01 from MEM/WB
// BEHAVIOUR
//  - Reset: all bundles, specifiers, mem_zero and the dst registers clear to 0.
//    As a result pc_src=0, pc_write=ifid_write=1, ifid_flush=0, fwd_a=fwd_b=00.
//  - ex_dst is combinational: regdst ? ID/EX rd : ID/EX rt.
//  - EX/MEM captures ex_dst into mem_dst and ex_zero into mem_zero. MEM/WB captures mem_dst into wb_dst.
//  - Latency: a bundle presented in ID appears at the ex_* ports 1 clk later.
//    It appears at mem_* 2 clk later and at wb_* 3 clk later.
//  - Load-use: stall = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt), combinational.
//    While stall: pc_write=ifid_write=0, and ID/EX loads an all-zero bundle (bubble).
//    EX/MEM and MEM/WB advance normally during a stall.
//  - Branch taken (pc_src=1): ifid_flush=1. At the next edge ID/EX and EX/MEM load zero bundles.
//    MEM/WB still captures the branch's own (WB=0) bundle.
//  - pc_src and stall in the same cycle: the flush wins. pc_write=ifid_write=1, stall ignored,
//    ID/EX zeroed.
//  - Forwarding, ex_rs/ex_rt vs mem_dst/wb_dst:
//    * Source 10 if mem_regwrite & mem_dst!=0 & mem_dst==src.
//    * Else source 01 if wb_regwrite & wb_dst!=0 & wb_dst==src.
//    * Else 00. EX/MEM has priority over MEM/WB.
//  - Register 0 never causes a stall or a forward.
//  - Reset asserted mid-stream drops all in-flight bundles immediately (async).
//    The first edge after release behaves as from an empty pipeline.
//  - Zero bundle means no regwrite, memread, memwrite or branch, so a bubble has no side effects.
// STRUCTURE
//  - Shared package ctrl_pkg: bundle widths (WB_W=2, M_W=3, EX_W=4), bit-index constants for each
//    field, the fwd_* encodings FWD_RF/FWD_MEM/FWD_WB and the NOP bundle constant.
//    The control unit uses the same package.
//  - One sub-module, fwd_unit: purely combinational forwarding selects, instantiated twice (A, B).
//  - The stall/flush logic and the three pipeline registers stay in this module.
// TESTING
//  - R-type: id_wb=01, id_m=000, id_exe=0111, rd=3 -> ex_regdst=1, ex_aluop=11, ex_alusrc=0
//    after 1 clk; wb_regwrite=1, wb_dst=3 after 3 clk.
//  - Load-use: LW (id_m=010, rt=5), then ADD with rs=5 -> exactly one cycle with pc_write=0,
//    ifid_write=0 and an all-zero ID/EX; the ADD proceeds the next cycle with fwd_a=01.
//  - Branch: BEQ (id_m=001) with ex_zero=1 -> pc_src=1 and ifid_flush=1 2 clk after ID.
//    The two younger bundles reach MEM/WB as zeros.
//  - Double hazard: ex_rs=4 with mem_dst=4 and wb_dst=4, both regwrite -> fwd_a=10.
//    With rs=0 in the same setup -> fwd_a=00.
//  - Simultaneous: pc_src=1 while the load-use condition is true -> pc_write=1, ifid_flush=1,
//    ID/EX zero, no stall cycle.
//  - Reset: reset low mid-stream with a LW in EX -> all outputs at reset values with no clock edge;
//    after release, the first instruction shows 1/2/3 clk latency.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-bundle definitions for the control unit and the pipeline hazard block.
// Field index constants locate each control bit inside its stage bundle.
package ctrl_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    localparam int M_BRANCH   = 0;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 2;

    localparam int EX_REGDST   = 0;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUSRC   = 3;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] exe;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t NOP_BUNDLE = '{wb: 2'b00, m: 3'b000, exe: 4'b0000};

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding select for one ALU operand.
// The younger producer in EX/MEM wins over MEM/WB; register 0 is never forwarded.
module fwd_unit
    import ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_src,
    input  logic            i_mem_regwrite,
    input  logic [RA_W-1:0] i_mem_dst,
    input  logic            i_wb_regwrite,
    input  logic [RA_W-1:0] i_wb_dst,
    output logic [1:0]      o_sel
);

    logic w_src_nz;
    logic w_mem_hit;
    logic w_wb_hit;

    // Match the operand against each in-flight destination and pick by priority.
    always_comb begin
        w_src_nz  = (i_src != {RA_W{1'b0}});
        w_mem_hit = i_mem_regwrite & w_src_nz & (i_mem_dst == i_src);
        w_wb_hit  = i_wb_regwrite & w_src_nz & (i_wb_dst == i_src);
        o_sel     = FWD_RF;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end else begin
            o_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Carries control bundles and register specifiers through ID/EX, EX/MEM and MEM/WB,
// and produces load-use stall, branch flush and forwarding selects.
module ctrl_pipe_hazard
    import ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WB_W-1:0] id_wb,
    input  logic [M_W-1:0]  id_m,
    input  logic [EX_W-1:0] id_exe,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            ex_zero,
    output logic            ex_regdst,
    output logic            ex_alusrc,
    output logic [1:0]      ex_aluop,
    output logic [RA_W-1:0] ex_rs,
    output logic [RA_W-1:0] ex_rt,
    output logic            mem_branch,
    output logic            mem_read,
    output logic            mem_write,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic [RA_W-1:0] wb_dst,
    output logic            pc_src,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    ctrl_bundle_t    r_ex_bundle;
    logic [RA_W-1:0] r_ex_rs;
    logic [RA_W-1:0] r_ex_rt;
    logic [RA_W-1:0] r_ex_rd;

    logic [WB_W-1:0] r_mem_wb;
    logic [M_W-1:0]  r_mem_m;
    logic [RA_W-1:0] r_mem_dst;
    logic            r_mem_zero;

    logic [WB_W-1:0] r_wb_wb;
    logic [RA_W-1:0] r_wb_dst;

    logic            w_pc_src;
    logic            w_load_use;
    logic            w_stall;
    logic            w_bubble;
    logic [RA_W-1:0] w_ex_dst;

    // Hazard decisions; a taken branch overrides a load-use stall since the stalled
    // instruction is being squashed anyway.
    always_comb begin
        w_pc_src   = r_mem_m[M_BRANCH] & r_mem_zero;
        w_load_use = r_ex_bundle.m[M_MEMREAD] & (r_ex_rt != {RA_W{1'b0}}) &
                     ((r_ex_rt == id_rs) | (r_ex_rt == id_rt));
        w_stall    = w_load_use & ~w_pc_src;
        w_bubble   = w_load_use | w_pc_src;
        w_ex_dst   = r_ex_bundle.exe[EX_REGDST] ? r_ex_rd : r_ex_rt;
    end

    // ID/EX register: takes the decoded bundle or a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_bundle <= NOP_BUNDLE;
            r_ex_rs     <= {RA_W{1'b0}};
            r_ex_rt     <= {RA_W{1'b0}};
            r_ex_rd     <= {RA_W{1'b0}};
        end else if (w_bubble) begin
            r_ex_bundle <= NOP_BUNDLE;
            r_ex_rs     <= {RA_W{1'b0}};
            r_ex_rt     <= {RA_W{1'b0}};
            r_ex_rd     <= {RA_W{1'b0}};
        end else begin
            r_ex_bundle <= '{wb: id_wb, m: id_m, exe: id_exe};
            r_ex_rs     <= id_rs;
            r_ex_rt     <= id_rt;
            r_ex_rd     <= id_rd;
        end
    end

    // EX/MEM register: squashed when the branch in MEM is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_wb   <= {WB_W{1'b0}};
            r_mem_m    <= {M_W{1'b0}};
            r_mem_dst  <= {RA_W{1'b0}};
            r_mem_zero <= 1'b0;
        end else if (w_pc_src) begin
            r_mem_wb   <= {WB_W{1'b0}};
            r_mem_m    <= {M_W{1'b0}};
            r_mem_dst  <= {RA_W{1'b0}};
            r_mem_zero <= 1'b0;
        end else begin
            r_mem_wb   <= r_ex_bundle.wb;
            r_mem_m    <= r_ex_bundle.m;
            r_mem_dst  <= w_ex_dst;
            r_mem_zero <= ex_zero;
        end
    end

    // MEM/WB register: always advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_wb  <= {WB_W{1'b0}};
            r_wb_dst <= {RA_W{1'b0}};
        end else begin
            r_wb_wb  <= r_mem_wb;
            r_wb_dst <= r_mem_dst;
        end
    end

    fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .i_src          (r_ex_rs),
        .i_mem_regwrite (r_mem_wb[WB_REGWRITE]),
        .i_mem_dst      (r_mem_dst),
        .i_wb_regwrite  (r_wb_wb[WB_REGWRITE]),
        .i_wb_dst       (r_wb_dst),
        .o_sel          (fwd_a)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .i_src          (r_ex_rt),
        .i_mem_regwrite (r_mem_wb[WB_REGWRITE]),
        .i_mem_dst      (r_mem_dst),
        .i_wb_regwrite  (r_wb_wb[WB_REGWRITE]),
        .i_wb_dst       (r_wb_dst),
        .o_sel          (fwd_b)
    );

    assign ex_regdst   = r_ex_bundle.exe[EX_REGDST];
    assign ex_alusrc   = r_ex_bundle.exe[EX_ALUSRC];
    assign ex_aluop    = r_ex_bundle.exe[EX_ALUOP_HI:EX_ALUOP_LO];
    assign ex_rs       = r_ex_rs;
    assign ex_rt       = r_ex_rt;
    assign mem_branch  = r_mem_m[M_BRANCH];
    assign mem_read    = r_mem_m[M_MEMREAD];
    assign mem_write   = r_mem_m[M_MEMWRITE];
    assign wb_regwrite = r_wb_wb[WB_REGWRITE];
    assign wb_memtoreg = r_wb_wb[WB_MEMTOREG];
    assign wb_dst      = r_wb_dst;
    assign pc_src      = w_pc_src;
    assign pc_write    = ~w_stall;
    assign ifid_write  = ~w_stall;
    assign ifid_flush  = w_pc_src;

endmodule
